// File: rtl/rom_pkg.sv
// Shared widths and FSM state encoding for the ROM read initiator.
package rom_pkg;

  localparam int ROM_ADDR_W = 4;
  localparam int ROM_DATA_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/rom_reader_if.sv
// ROM address/data bus plus the downstream valid/ready word stream.
// master = rom_reader side, slave = ROM bank and word consumer side.
interface rom_reader_if
  import rom_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = ROM_DATA_W
) ();

  logic [ADDR_W-1:0] rom_addr;
  logic              rom_ce;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output rom_addr, rom_ce, out_data, out_valid,
    input  rom_data, out_ready
  );

  modport slave (
    input  rom_addr, rom_ce, out_data, out_valid,
    output rom_data, out_ready
  );

endinterface

// File: rtl/rom16x4.sv
// 16x4 ROM bank with contents mem[i] = i ^ 4'hA; output reads 0 when not enabled.
module rom16x4 (
  input  logic [3:0] addr,
  input  logic       ce,
  output logic [3:0] data
);

  assign data = ce ? (addr ^ 4'hA) : 4'h0;

endmodule

// File: rtl/rom_addr_ctr.sv
// Burst address generator: wrapping address counter plus remaining-word down-counter.
module rom_addr_ctr
  import rom_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   REMAIN_ONE = (ADDR_W + 1)'(1);

  logic [ADDR_W:0] remain;

  // Terminal count: the word currently held is the final one of the burst.
  assign last = (remain == REMAIN_ONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      addr   <= '0;
      remain <= '0;
    end else if (load) begin
      addr   <= base;
      remain <= count;
    end else if (step) begin
      remain <= remain - REMAIN_ONE;
      // Address only advances when another word follows, so it stays on the last one read.
      if (!last) begin
        addr <= addr + ADDR_ONE;
      end
    end
  end

endmodule

// File: rtl/rom_reader.sv
// Burst read initiator for the 16x4 ROM bank with valid/ready word output.
// Optional burst checksum enabled by defining ROM_READER_CHECKSUM_EN.
module rom_reader
  import rom_pkg::*;
#(
  parameter int ADDR_W      = ROM_ADDR_W,
  parameter int DATA_W      = ROM_DATA_W,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum,
  rom_reader_if.master      bus
);

  // state  | meaning
  // IDLE   | waiting for start; count latched on start
  // ACCESS | ROM enabled, counting down access time, then capture word
  // HOLD   | word presented downstream, waiting for out_ready
  // DONE   | one-cycle done pulse, then back to IDLE

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t            state;
  logic [3:0]        wait_cnt;
  logic              rom_ce_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;
  logic              ctr_load;
  logic              ctr_step;
  logic [ADDR_W-1:0] addr;
  logic              last;

  assign ctr_load = (state == IDLE) && start;
  assign ctr_step = (state == HOLD) && out_valid_q && bus.out_ready;

  rom_addr_ctr #(.ADDR_W(ADDR_W)) u_ctr (
    .clk   (clk),
    .reset (reset),
    .load  (ctr_load),
    .step  (ctr_step),
    .base  (base),
    .count (count),
    .addr  (addr),
    .last  (last)
  );

  assign bus.rom_addr  = addr;
  assign bus.rom_ce    = rom_ce_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rom_ce_q    <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (count == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= ACCESS;
              rom_ce_q <= 1'b1;
              wait_cnt <= WAIT_INIT;
            end
          end
        end
        ACCESS: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            // rom_data is only looked at here, while the ROM is enabled.
            out_data_q  <= bus.rom_data;
            out_valid_q <= 1'b1;
            rom_ce_q    <= 1'b0;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (last) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= ACCESS;
              rom_ce_q <= 1'b1;
              wait_cnt <= WAIT_INIT;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ROM_READER_CHECKSUM_EN
  logic [DATA_W-1:0] csum;

  // Accumulates on the same edge the word is accepted, so it is final by the DONE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      csum <= '0;
    end else if (ctr_load) begin
      csum <= '0;
    end else if (ctr_step) begin
      csum <= csum + out_data_q;
    end
  end

  assign checksum = csum;
`else
  assign checksum = '0;
`endif

endmodule
